// File: rtl/nn_pkg.sv
// ============================================================================
// Module   : nn_pkg
// Brief    : Shared types and constants for the sample responder block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nn_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_X     = 3'd1,
        S_RD_T     = 3'd2,
        S_WAIT_MEM = 3'd3,
        S_START    = 3'd4,
        S_RUN      = 3'd5,
        S_RESP     = 3'd6
    } state_e;

    typedef enum logic {
        K_TRAIN = 1'b0,
        K_VALID = 1'b1
    } kind_e;

    localparam int RECORD_WORDS = 2;

    // Largest positive value of a signed word of the given width.
    function automatic int err_max(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    localparam int ERR_MAX = err_max(16);

endpackage

`default_nettype wire

// File: rtl/err_unit.sv
// ============================================================================
// Module   : err_unit
// Brief    : Combinational per-sample error: |tgt-out| or ((tgt-out)^2)>>FRAC,
//            saturated to the largest positive word. Option macro: ERR_SQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module err_unit
    import nn_pkg::*;
#(
    parameter int BITS = 16,
    parameter int FRAC = 8
) (
    input  logic [BITS-1:0] tgt_i,
    input  logic [BITS-1:0] out_i,
    output logic [BITS-1:0] err_o
);

    localparam int MAG_W = 2 * BITS + 2;
    localparam logic [MAG_W-1:0] C_ERR_MAX = MAG_W'(err_max(BITS));

    logic signed [BITS:0]  w_tgt_ext;
    logic signed [BITS:0]  w_out_ext;
    logic signed [BITS:0]  w_diff;
    logic [MAG_W-1:0]      w_mag;

    assign w_tgt_ext = {tgt_i[BITS-1], tgt_i};
    assign w_out_ext = {out_i[BITS-1], out_i};
    assign w_diff    = w_tgt_ext - w_out_ext;

`ifdef ERR_SQ_EN
    logic signed [MAG_W-1:0] w_diff_wide;
    logic signed [MAG_W-1:0] w_prod;

    assign w_diff_wide = {{(MAG_W - BITS - 1){w_diff[BITS]}}, w_diff};
    assign w_prod      = w_diff_wide * w_diff_wide;
    assign w_mag       = $unsigned(w_prod) >> FRAC;
`else
    // Magnitude of a BITS+1 signed value always fits BITS+1 unsigned bits.
    logic [BITS:0] w_abs;

    assign w_abs = w_diff[BITS] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_mag = {{(MAG_W - BITS - 1){1'b0}}, w_abs};
`endif

    assign err_o = (w_mag > C_ERR_MAX) ? C_ERR_MAX[BITS-1:0] : w_mag[BITS-1:0];

endmodule

`default_nettype wire

// File: rtl/sample_responder.sv
// ============================================================================
// Module   : sample_responder
// Brief    : Turns train/validation requests into two-word sample fetches and
//            network runs; returns done/error handshakes. Option macro:
//            ERR_SQ_EN (squared error, lives in err_unit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_responder
    import nn_pkg::*;
#(
    parameter int BITS       = 16,
    parameter int ADDR_W     = 10,
    parameter int TRAIN_BASE = 0,
    parameter int VALID_BASE = 512,
    parameter int MEM_LAT    = 1,
    parameter int FRAC       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tr_req,
    input  logic              vl_req,
    input  logic              end_i,
    output logic              s_train,
    output logic              s_error,
    output logic [BITS-1:0]   err,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [BITS-1:0]   mem_rdata,
    output logic              net_start,
    output logic              net_train,
    output logic [BITS-1:0]   net_x,
    output logic [BITS-1:0]   net_tgt,
    input  logic [BITS-1:0]   net_out,
    input  logic              net_done,
    output logic              busy,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] C_TRAIN_BASE = ADDR_W'(TRAIN_BASE);
    localparam logic [ADDR_W-1:0] C_VALID_BASE = ADDR_W'(VALID_BASE);
    localparam logic [ADDR_W-1:0] C_REC_STEP   = ADDR_W'(RECORD_WORDS);

    state_e              state_q,   state_d;
    kind_e               kind_q,    kind_d;
    logic [ADDR_W-1:0]   ptr_q,     ptr_d;
    logic [ADDR_W-1:0]   tr_ptr_q,  tr_ptr_d;
    logic [ADDR_W-1:0]   vl_ptr_q,  vl_ptr_d;
    logic                overrun_q, overrun_d;
    logic [BITS-1:0]     err_q,     err_d;
    logic [BITS-1:0]     net_x_q,   net_x_d;
    logic [BITS-1:0]     net_tgt_q, net_tgt_d;
    logic [MEM_LAT-1:0]  vx_q;
    logic [MEM_LAT-1:0]  vt_q;
    logic [BITS-1:0]     w_err;

    err_unit #(
        .BITS (BITS),
        .FRAC (FRAC)
    ) u_err_unit (
        .tgt_i (net_tgt_q),
        .out_i (net_out),
        .err_o (w_err)
    );

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        ptr_d     = ptr_q;
        tr_ptr_d  = tr_ptr_q;
        vl_ptr_d  = vl_ptr_q;
        overrun_d = overrun_q;
        err_d     = err_q;
        net_x_d   = net_x_q;
        net_tgt_d = net_tgt_q;

        if (end_i) begin
            state_d  = S_IDLE;
            kind_d   = K_TRAIN;
            tr_ptr_d = C_TRAIN_BASE;
            vl_ptr_d = C_VALID_BASE;
        end else begin
            if (vx_q[MEM_LAT-1]) net_x_d   = mem_rdata;
            if (vt_q[MEM_LAT-1]) net_tgt_d = mem_rdata;

            case (state_q)
                S_IDLE: begin
                    if (tr_req) begin
                        state_d = S_RD_X;
                        kind_d  = K_TRAIN;
                        // First train request after validation starts a new epoch.
                        if (kind_q == K_VALID) begin
                            ptr_d    = C_TRAIN_BASE;
                            tr_ptr_d = C_TRAIN_BASE;
                            vl_ptr_d = C_VALID_BASE;
                        end else begin
                            ptr_d = tr_ptr_q;
                        end
                        if (vl_req) overrun_d = 1'b1;
                    end else if (vl_req) begin
                        state_d = S_RD_X;
                        kind_d  = K_VALID;
                        ptr_d   = vl_ptr_q;
                    end
                end
                S_RD_X:     state_d = S_RD_T;
                S_RD_T:     state_d = S_WAIT_MEM;
                S_WAIT_MEM: if (vt_q[MEM_LAT-1]) state_d = S_START;
                S_START: begin
                    state_d = S_RUN;
                    if (kind_q == K_TRAIN) tr_ptr_d = ptr_q + C_REC_STEP;
                    else                   vl_ptr_d = ptr_q + C_REC_STEP;
                end
                S_RUN: begin
                    if (net_done) begin
                        state_d = S_RESP;
                        if (kind_q == K_VALID) err_d = w_err;
                    end
                end
                S_RESP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase

            if ((state_q != S_IDLE) && (tr_req || vl_req)) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            kind_q    <= K_TRAIN;
            ptr_q     <= C_TRAIN_BASE;
            tr_ptr_q  <= C_TRAIN_BASE;
            vl_ptr_q  <= C_VALID_BASE;
            overrun_q <= 1'b0;
            err_q     <= '0;
            net_x_q   <= '0;
            net_tgt_q <= '0;
            vx_q      <= '0;
            vt_q      <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            ptr_q     <= ptr_d;
            tr_ptr_q  <= tr_ptr_d;
            vl_ptr_q  <= vl_ptr_d;
            overrun_q <= overrun_d;
            err_q     <= err_d;
            net_x_q   <= net_x_d;
            net_tgt_q <= net_tgt_d;
            // Read-issue tags ride alongside the memory pipeline; an abort flushes them.
            vx_q[0]   <= !end_i && (state_q == S_RD_X);
            vt_q[0]   <= !end_i && (state_q == S_RD_T);
            for (int i = 1; i < MEM_LAT; i++) begin
                vx_q[i] <= !end_i && vx_q[i-1];
                vt_q[i] <= !end_i && vt_q[i-1];
            end
        end
    end

    assign mem_rd    = (state_q == S_RD_X) || (state_q == S_RD_T);
    assign mem_addr  = (state_q == S_RD_X) ? ptr_q :
                       (state_q == S_RD_T) ? (ptr_q + ADDR_W'(1)) : '0;
    assign net_start = (state_q == S_START);
    assign net_train = ((state_q == S_START) || (state_q == S_RUN)) && (kind_q == K_TRAIN);
    assign net_x     = net_x_q;
    assign net_tgt   = net_tgt_q;
    assign s_train   = (state_q == S_RESP) && (kind_q == K_TRAIN);
    assign s_error   = (state_q == S_RESP) && (kind_q == K_VALID);
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_responder.sv
// ============================================================================
// Module   : tb_sample_responder
// Brief    : Directed self-checking bench for sample_responder (MEM_LAT=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sample_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tr_req, vl_req, end_i;
    logic        s_train, s_error;
    logic [15:0] err;
    logic        mem_rd;
    logic [9:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        net_start, net_train;
    logic [15:0] net_x, net_tgt, net_out;
    logic        net_done;
    logic        busy, overrun;

    logic [15:0] mem [0:1023];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    sample_responder #(
        .BITS       (16),
        .ADDR_W     (10),
        .TRAIN_BASE (0),
        .VALID_BASE (512),
        .MEM_LAT    (1),
        .FRAC       (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tr_req    (tr_req),
        .vl_req    (vl_req),
        .end_i     (end_i),
        .s_train   (s_train),
        .s_error   (s_error),
        .err       (err),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .net_start (net_start),
        .net_train (net_train),
        .net_x     (net_x),
        .net_tgt   (net_tgt),
        .net_out   (net_out),
        .net_done  (net_done),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full request: fixed MEM_LAT=1 timing, net_done 3 cycles after net_start.
    task automatic run_req(input string tag, input logic tr, input logic vl, input logic poke,
                           input logic [9:0] a, input logic [15:0] x, input logic [15:0] t,
                           input logic [15:0] nout, input logic [15:0] e);
        logic is_val;
        is_val = vl & ~tr;
        tr_req = tr;
        vl_req = vl;
        @(negedge clk);
        tr_req = 1'b0;
        vl_req = 1'b0;
        check_eq({tag, ":rd_x"}, 32'(mem_rd), 32'd1);
        check_eq({tag, ":addr_x"}, 32'(mem_addr), 32'(a));
        @(negedge clk);
        check_eq({tag, ":addr_t"}, 32'(mem_addr), 32'(a + 10'd1));
        @(negedge clk);
        check_eq({tag, ":busy_wait"}, 32'(busy), 32'd1);
        @(negedge clk);
        check_eq({tag, ":start"}, 32'(net_start), 32'd1);
        check_eq({tag, ":train"}, 32'(net_train), 32'(!is_val));
        check_eq({tag, ":net_x"}, 32'(net_x), 32'(x));
        check_eq({tag, ":net_tgt"}, 32'(net_tgt), 32'(t));
        @(negedge clk);
        if (poke) tr_req = 1'b1;
        @(negedge clk);
        tr_req = 1'b0;
        check_eq({tag, ":start_pulse"}, 32'(net_start), 32'd0);
        check_eq({tag, ":train_run"}, 32'(net_train), 32'(!is_val));
        @(negedge clk);
        net_done = 1'b1;
        net_out  = nout;
        @(negedge clk);
        net_done = 1'b0;
        check_eq({tag, ":s_train"}, 32'(s_train), 32'(!is_val));
        check_eq({tag, ":s_error"}, 32'(s_error), 32'(is_val));
        if (is_val) check_eq({tag, ":err"}, 32'(err), 32'(e));
        @(negedge clk);
        check_eq({tag, ":idle"}, 32'({busy, s_train, s_error}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] e_val;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h0100; mem[1]   = 16'h0200;
        mem[2]   = 16'h0011; mem[3]   = 16'h0022;
        mem[4]   = 16'h0033; mem[5]   = 16'h0044;
        mem[6]   = 16'h0055; mem[7]   = 16'h0066;
        mem[512] = 16'h0005; mem[513] = 16'h0300;
        mem[514] = 16'h0000; mem[515] = 16'h7FFF;
        mem[516] = 16'h0000; mem[517] = 16'h8000;

        rst_n = 1'b0; tr_req = 1'b0; vl_req = 1'b0; end_i = 1'b0;
        net_done = 1'b0; net_out = 16'h0; mem_rdata = 16'h0;
        #3;
        check_eq("rst_outs", 32'({s_train, s_error, mem_rd, net_start, net_train, busy, overrun}), 32'd0);
        check_eq("rst_vals", {err, mem_addr, 6'd0}, 32'd0);
        check_eq("rst_net", {net_x, net_tgt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_req("tr0", 1'b1, 1'b0, 1'b0, 10'd0, 16'h0100, 16'h0200, 16'h0150, 16'h0);
        run_req("tr1", 1'b1, 1'b0, 1'b0, 10'd2, 16'h0011, 16'h0022, 16'h0000, 16'h0);
`ifdef ERR_SQ_EN
        e_val = 16'h0400;
`else
        e_val = 16'h0200;
`endif
        run_req("vl0", 1'b0, 1'b1, 1'b0, 10'd512, 16'h0005, 16'h0300, 16'h0100, e_val);
        run_req("sat_pos", 1'b0, 1'b1, 1'b0, 10'd514, 16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF);
        run_req("sat_neg", 1'b0, 1'b1, 1'b0, 10'd516, 16'h0000, 16'h8000, 16'h7FFF, 16'h7FFF);
        check_eq("no_overrun", 32'(overrun), 32'd0);

        run_req("rewind", 1'b1, 1'b0, 1'b0, 10'd0, 16'h0100, 16'h0200, 16'h1234, 16'h0);
        check_eq("err_hold", 32'(err), 32'h7FFF);

        run_req("poke", 1'b1, 1'b0, 1'b1, 10'd2, 16'h0011, 16'h0022, 16'h0000, 16'h0);
        check_eq("overrun_run", 32'(overrun), 32'd1);
        run_req("both", 1'b1, 1'b1, 1'b0, 10'd4, 16'h0033, 16'h0044, 16'h0000, 16'h0);
        check_eq("overrun_sticky", 32'(overrun), 32'd1);

        // Abort mid-run: no response, pointers rewound.
        tr_req = 1'b1;
        @(negedge clk); tr_req = 1'b0;
        check_eq("abort:addr_x", 32'(mem_addr), 32'd6);
        repeat (3) @(negedge clk);
        check_eq("abort:start", 32'(net_start), 32'd1);
        @(negedge clk);
        end_i = 1'b1;
        @(negedge clk);
        end_i = 1'b0;
        check_eq("abort:idle", 32'(busy), 32'd0);
        net_done = 1'b1;
        @(negedge clk);
        net_done = 1'b0;
        check_eq("abort:no_resp", 32'({busy, s_train, s_error}), 32'd0);
        run_req("post_abort", 1'b1, 1'b0, 1'b0, 10'd0, 16'h0100, 16'h0200, 16'h0000, 16'h0);

        // Asynchronous reset while waiting for memory.
        tr_req = 1'b1;
        @(negedge clk); tr_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("arst:pre_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst:outs", 32'({s_train, s_error, mem_rd, net_start, net_train, busy, overrun}), 32'd0);
        check_eq("arst:net", {net_x, net_tgt}, 32'd0);
        check_eq("arst:err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
